// File: rtl/mem_bus_adapter.sv
// -----------------------------------------------------------------------------
// mem_bus_adapter
//
// Bridges the multicycle datapath memory port to a word-addressed external bus
// with a variable-latency req/ack handshake. The controller raises core_rd or
// core_wr for one sample, waits while core_busy is high, and advances on
// core_done (success) or core_err (misaligned address or bus timeout).
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   core_rd, core_wr     request strobes, sampled only while idle
//   core_addr            byte address; low two bits must be zero
//   core_wdata           store data
//   core_rdata           read data, held until the next successful read
//   core_busy            high whenever a request is in progress
//   core_done            one-cycle pulse on successful completion
//   core_err             one-cycle pulse on misalignment or timeout
//   err_sticky           set on any error, cleared only by rst
//   bus_req/we/addr/wdata  bus request and its latched attributes
//   bus_ack, bus_rdata   bus completion and read data (valid with bus_ack)
// -----------------------------------------------------------------------------
module mem_bus_adapter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic              err_sticky,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  // A zero TIMEOUT still needs a one-bit counter so the logic stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // Saturating increment: the counter parks at TIMEOUT instead of wrapping.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // cnt counts ISSUE edges already taken; the edge that would bring it to
  // TIMEOUT is the last one allowed, so bus_req is high exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_MAX);

  // Handshake outputs are pure state decodes, so there is no combinational
  // path from any input to any output.
  assign core_busy = (state != IDLE);
  assign bus_req   = (state == ISSUE);
  assign core_done = (state == DONE);
  assign core_err  = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      core_rdata <= '0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (core_rd || core_wr) begin
            // A simultaneous read is dropped in favour of the write.
            bus_we    <= core_wr;
            bus_addr  <= core_addr;
            bus_wdata <= core_wdata;
            if (core_addr[1:0] != 2'b00) begin
              state      <= ERR;
              err_sticky <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          cnt <= cnt_inc;
          // Ack is checked first so it wins over a timeout on the same edge.
          if (bus_ack) begin
            if (!bus_we) begin
              core_rdata <= bus_rdata;
            end
            state <= DONE;
          end else if (timeout_hit) begin
            state      <= ERR;
            err_sticky <= 1'b1;
          end
        end

        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end

        ERR: begin
          cnt   <= '0;
          state <= IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
